// File: rtl/imem_responder.sv
// Instruction-memory responder: credit-limited fetch pipeline feeding an in-order response FIFO.
// Optional write port enabled by defining IMEM_WRITE_PORT_EN.
module imem_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_addr,
  output logic [31:0] resp_instr,
  output logic        resp_fault
`ifdef IMEM_WRITE_PORT_EN
  ,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
`endif
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam int          MAX_OUT    = LATENCY + 2;
  localparam int          PW         = $clog2(MAX_OUT);
  localparam int          CW         = $clog2(MAX_OUT + 1);
  localparam int          NSTG       = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  logic [31:0] store [DEPTH_WORDS];

  logic          accept, pop, in_fault;
  logic [31:0]   in_instr;

  logic          stg_valid_q [NSTG];
  logic          stg_valid_d [NSTG];
  logic [31:0]   stg_addr_q  [NSTG];
  logic [31:0]   stg_addr_d  [NSTG];
  logic [31:0]   stg_instr_q [NSTG];
  logic [31:0]   stg_instr_d [NSTG];
  logic          stg_fault_q [NSTG];
  logic          stg_fault_d [NSTG];

  logic [31:0]   fifo_addr_q  [MAX_OUT];
  logic [31:0]   fifo_addr_d  [MAX_OUT];
  logic [31:0]   fifo_instr_q [MAX_OUT];
  logic [31:0]   fifo_instr_d [MAX_OUT];
  logic          fifo_fault_q [MAX_OUT];
  logic          fifo_fault_d [MAX_OUT];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, out_q, out_d;

  logic          push, push_fault;
  logic [31:0]   push_addr, push_instr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_ready  = (out_q < CW'(MAX_OUT));
  assign accept     = req_valid && req_ready;
  assign resp_valid = (count_q != '0);
  assign pop        = resp_valid && resp_ready;
  assign in_fault   = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);
  assign in_instr   = in_fault ? NOP : store[req_addr[AW+1:2]];

  // The first stage always takes the new request, so a redirect accepted on a flush edge survives.
  always_comb begin
    stg_valid_d    = stg_valid_q;
    stg_addr_d     = stg_addr_q;
    stg_instr_d    = stg_instr_q;
    stg_fault_d    = stg_fault_q;
    stg_valid_d[0] = accept;
    stg_addr_d[0]  = req_addr;
    stg_instr_d[0] = in_instr;
    stg_fault_d[0] = in_fault;
    for (int i = 1; i < NSTG; i++) begin
      stg_valid_d[i] = stg_valid_q[i-1] && !flush;
      stg_addr_d[i]  = stg_addr_q[i-1];
      stg_instr_d[i] = stg_instr_q[i-1];
      stg_fault_d[i] = stg_fault_q[i-1];
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push       = accept;
      assign push_addr  = req_addr;
      assign push_instr = in_instr;
      assign push_fault = in_fault;
    end else begin : g_piped
      assign push       = stg_valid_q[NSTG-1] && !flush;
      assign push_addr  = stg_addr_q[NSTG-1];
      assign push_instr = stg_instr_q[NSTG-1];
      assign push_fault = stg_fault_q[NSTG-1];
    end
  endgenerate

  always_comb begin
    fifo_addr_d  = fifo_addr_q;
    fifo_instr_d = fifo_instr_q;
    fifo_fault_d = fifo_fault_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = push ? PW'(1) : '0;
      count_d  = push ? CW'(1) : '0;
      if (push) begin
        fifo_addr_d[0]  = push_addr;
        fifo_instr_d[0] = push_instr;
        fifo_fault_d[0] = push_fault;
      end
    end else begin
      if (push) begin
        fifo_addr_d[wr_ptr_q]  = push_addr;
        fifo_instr_d[wr_ptr_q] = push_instr;
        fifo_fault_d[wr_ptr_q] = push_fault;
        wr_ptr_d               = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
    out_d = flush ? CW'(accept) : out_q + CW'(accept) - CW'(pop);
  end

  assign resp_addr  = resp_valid ? fifo_addr_q[rd_ptr_q]  : '0;
  assign resp_instr = resp_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign resp_fault = resp_valid ? fifo_fault_q[rd_ptr_q] : 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSTG; i++) begin
        stg_valid_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
    end
  end

  // Payload registers need no reset: outputs are gated by resp_valid.
  always_ff @(posedge clk) begin
    stg_addr_q   <= stg_addr_d;
    stg_instr_q  <= stg_instr_d;
    stg_fault_q  <= stg_fault_d;
    fifo_addr_q  <= fifo_addr_d;
    fifo_instr_q <= fifo_instr_d;
    fifo_fault_q <= fifo_fault_d;
  end

`ifdef IMEM_WRITE_PORT_EN
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr[1:0] == 2'b00) && (wr_addr < ADDR_LIMIT)) begin
      store[wr_addr[AW+1:2]] <= wr_data;
    end
  end
`endif

endmodule
